// File: rtl/ram_request_sequencer_pkg.sv
// Shared types for the RAM request sequencer: FSM states, memory command record
// and byte-enable codes.
package ram_seq_pkg;

    localparam int RAM_ADDR_WIDTH  = 22;
    localparam int WORD_ADDR_WIDTH = RAM_ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RFSH = 2'd3
    } seq_state_t;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_EVEN = 2'b01;
    localparam logic [1:0] BE_ODD  = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    typedef struct packed {
        logic                       we;
        logic                       rfsh;
        logic [WORD_ADDR_WIDTH-1:0] addr;
        logic [1:0]                 be;
        logic [15:0]                wdata;
    } mem_cmd_t;

    localparam mem_cmd_t CMD_NONE = '0;

    function automatic logic [1:0] byte_be(input logic lsb);
        return lsb ? BE_ODD : BE_EVEN;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic lsb);
        return lsb ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/ram_request_sequencer_if.sv
// Request/acknowledge bus between the sequencer (master) and the memory back-end (slave).
interface ram_request_sequencer_if
    import ram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
);
    logic                  MEM_REQ;
    logic                  MEM_WE;
    logic                  MEM_RFSH;
    logic [ADDR_WIDTH-2:0] MEM_ADDR;
    logic [1:0]            MEM_BE;
    logic [15:0]           MEM_WDATA;
    logic                  MEM_ACK;
    logic [15:0]           MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_RFSH, MEM_ADDR, MEM_BE, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_RFSH, MEM_ADDR, MEM_BE, MEM_WDATA,
        output MEM_ACK, MEM_RDATA
    );

endinterface

// File: rtl/ram_request_sequencer_read_cache.sv
// One-word read cache: a single tag/data/valid entry with lookup, fill,
// byte-update (write-through snoop) and invalidate.
module ram_read_cache
    import ram_seq_pkg::*;
#(
    parameter int WORD_ADDR_W = WORD_ADDR_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RESET_n,
    input  logic [WORD_ADDR_W-1:0] lookup_addr,
    input  logic                   lookup_lsb,
    output logic                   hit,
    output logic [7:0]             hit_byte,
    input  logic                   fill_en,
    input  logic [WORD_ADDR_W-1:0] fill_addr,
    input  logic [15:0]            fill_data,
    input  logic                   upd_en,
    input  logic [WORD_ADDR_W-1:0] upd_addr,
    input  logic                   upd_lsb,
    input  logic [7:0]             upd_byte,
    input  logic                   inval
);

    logic                   valid;
    logic [WORD_ADDR_W-1:0] tag;
    logic [15:0]            data;

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            valid <= 1'b0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
        end
    end

    // NOTE: tag and data carry no reset; they are meaningless until valid is
    // set, so only the valid bit needs one.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag  <= fill_addr;
            data <= fill_data;
        end else if (upd_en && valid && (upd_addr == tag)) begin
            if (upd_lsb) data[15:8] <= upd_byte;
            else         data[7:0]  <= upd_byte;
        end
    end

    assign hit      = valid && (lookup_addr == tag);
    assign hit_byte = byte_sel(data, lookup_lsb);

endmodule

// File: rtl/ram_request_sequencer.sv
// Turns the host byte-wide RAM strobes into 16-bit request/acknowledge transactions,
// with edge-detected launch, a one-word read cache, refresh forwarding and a timeout.
module ram_request_sequencer
    import ram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = RAM_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit USE_CACHE      = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [ADDR_WIDTH-1:0] RAM_ADDR,
    input  logic                  RAM_WE_n,
    input  logic                  RAM_OE_n,
    input  logic [7:0]            RAM_DIN,
    input  logic                  RAM_RFSH_n,
    output logic [15:0]           RAM_DOUT,
    ram_request_sequencer_if.master mem,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t state, state_next;

    logic                  prev_oe_n, prev_we_n, prev_rfsh_n;
    logic                  rd_start, wr_start, rfsh_start, new_start;
    logic                  pend_valid, pend_wr;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [7:0]            pend_din;
    logic                  rfsh_pend;
    mem_cmd_t              cmd, launch_cmd;
    logic                  cur_lsb;
    logic [CNT_W-1:0]      tmo_cnt;
    logic [7:0]            dout_q;
    logic                  err_q;

    logic                  acc_valid, acc_wr;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [7:0]            acc_din;
    logic [WORD_ADDR_WIDTH-1:0] acc_word;
    logic                  launch, hit_take, ack, tmo_hit;
    logic                  cache_hit;
    logic [7:0]            cache_byte;

    assign rd_start   = prev_oe_n & ~RAM_OE_n;
    assign wr_start   = prev_we_n & ~RAM_WE_n;
    assign rfsh_start = prev_rfsh_n & ~RAM_RFSH_n;
    assign new_start  = rd_start | wr_start;

    // ACK only counts while a request is outstanding; the ACK wins a tie with the timeout.
    assign ack     = (state != IDLE) && mem.MEM_ACK;
    assign tmo_hit = (state != IDLE) && !mem.MEM_ACK && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        acc_valid  = 1'b0;
        acc_wr     = pend_wr;
        acc_addr   = pend_addr;
        acc_din    = pend_din;
        launch     = 1'b0;
        launch_cmd = CMD_NONE;
        hit_take   = 1'b0;

        // A fresh edge overrides an older pending access; write beats read.
        if (new_start) begin
            acc_valid = 1'b1;
            acc_wr    = wr_start;
            acc_addr  = RAM_ADDR;
            acc_din   = RAM_DIN;
        end else if (pend_valid) begin
            acc_valid = 1'b1;
        end
        acc_word = WORD_ADDR_WIDTH'(acc_addr[ADDR_WIDTH-1:1]);

        case (state)
            IDLE: begin
                if (acc_valid && acc_wr) begin
                    state_next       = WR;
                    launch           = 1'b1;
                    launch_cmd.we    = 1'b1;
                    launch_cmd.addr  = acc_word;
                    launch_cmd.be    = byte_be(acc_addr[0]);
                    launch_cmd.wdata = {acc_din, acc_din};
                end else if (acc_valid && cache_hit) begin
                    hit_take = 1'b1;
                end else if (acc_valid) begin
                    state_next      = RD;
                    launch          = 1'b1;
                    launch_cmd.addr = acc_word;
                    launch_cmd.be   = BE_WORD;
                end else if (rfsh_pend) begin
                    state_next      = RFSH;
                    launch          = 1'b1;
                    launch_cmd.rfsh = 1'b1;
                end
            end
            default: begin
                if (ack || tmo_hit) state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            prev_oe_n   <= 1'b1;
            prev_we_n   <= 1'b1;
            prev_rfsh_n <= 1'b1;
            pend_valid  <= 1'b0;
            pend_wr     <= 1'b0;
            pend_addr   <= '0;
            pend_din    <= '0;
            rfsh_pend   <= 1'b0;
            cmd         <= CMD_NONE;
            cur_lsb     <= 1'b0;
            tmo_cnt     <= '0;
            dout_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            prev_oe_n   <= RAM_OE_n;
            prev_we_n   <= RAM_WE_n;
            prev_rfsh_n <= RAM_RFSH_n;

            if (state != IDLE) begin
                if (new_start) begin
                    pend_valid <= 1'b1;
                    pend_wr    <= wr_start;
                    pend_addr  <= RAM_ADDR;
                    pend_din   <= RAM_DIN;
                end
            end else begin
                pend_valid <= 1'b0;
            end

            // An aborted refresh is dropped rather than retried.
            if (rfsh_start)                             rfsh_pend <= 1'b1;
            else if (state == RFSH && (ack || tmo_hit)) rfsh_pend <= 1'b0;

            if (launch) begin
                cmd     <= launch_cmd;
                cur_lsb <= acc_addr[0];
                tmo_cnt <= '0;
            end else if (state != IDLE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (hit_take)                     dout_q <= cache_byte;
            else if (state == RD && ack)      dout_q <= byte_sel(mem.MEM_RDATA, cur_lsb);
            else if (state == RD && tmo_hit)  dout_q <= 8'hFF;

            if (tmo_hit) err_q <= 1'b1;
        end
    end

    generate
        if (USE_CACHE) begin : g_cache
            ram_read_cache #(.WORD_ADDR_W(WORD_ADDR_WIDTH)) u_cache (
                .CLK         (CLK),
                .RESET_n     (RESET_n),
                .lookup_addr (acc_word),
                .lookup_lsb  (acc_addr[0]),
                .hit         (cache_hit),
                .hit_byte    (cache_byte),
                .fill_en     (state == RD && ack),
                .fill_addr   (cmd.addr),
                .fill_data   (mem.MEM_RDATA),
                .upd_en      (state == WR && ack),
                .upd_addr    (cmd.addr),
                .upd_lsb     (cur_lsb),
                .upd_byte    (cmd.wdata[7:0]),
                .inval       (1'b0)
            );
        end else begin : g_no_cache
            assign cache_hit  = 1'b0;
            assign cache_byte = 8'h00;
        end
    endgenerate

    assign mem.MEM_REQ   = (state != IDLE);
    assign mem.MEM_WE    = cmd.we;
    assign mem.MEM_RFSH  = cmd.rfsh;
    assign mem.MEM_ADDR  = (ADDR_WIDTH-1)'(cmd.addr);
    assign mem.MEM_BE    = cmd.be;
    assign mem.MEM_WDATA = cmd.wdata;

    // Zero while OE_n is high so several RAM sources can be OR-combined.
    assign RAM_DOUT = RAM_OE_n ? 16'h0000 : {8'h00, dout_q};
    assign BUSY     = (state != IDLE);
    assign ERR      = err_q;

endmodule

// File: doc/ram_request_sequencer.md
Name: ram_request_sequencer

Overview:
- Downstream stage of the megarom controller. Consumes the byte-wide host-side RAM strobe bundle (ADDR, WE_n, OE_n, DIN, DOUT, RFSH_n) and converts it into a 16-bit request/acknowledge transaction stream for the memory back-end (PSRAM/SDRAM controller).
- Provides edge-detected access launch, a one-word read cache, refresh forwarding and an acknowledge timeout.

Parameters:
ADDR_WIDTH, 22, host byte-address width; the memory word address is ADDR_WIDTH-1 bits
TIMEOUT_CYCLES, 255, cycles MEM_REQ may stay unacknowledged before the request is aborted
USE_CACHE, 1, 1 = one-word read cache enabled; 0 = every read is issued to memory

Ports:
CLK  in  1  system clock; single clock domain
RESET_n  in  1  synchronous, active-low reset
RAM_ADDR  in  ADDR_WIDTH  host byte address
RAM_WE_n  in  1  host write strobe, active low
RAM_OE_n  in  1  host read strobe, active low
RAM_DIN  in  8  host write data
RAM_RFSH_n  in  1  host refresh strobe, active low
RAM_DOUT  out  16  read data; byte in [7:0], [15:8]=0
MEM_REQ  out  1  request valid
MEM_WE  out  1  1=write, 0=read (meaningful when MEM_RFSH=0)
MEM_RFSH  out  1  request is a refresh
MEM_ADDR  out  ADDR_WIDTH-1  word address = RAM_ADDR[ADDR_WIDTH-1:1]
MEM_BE  out  2  byte enables; bit0=even byte, bit1=odd byte
MEM_WDATA  out  16  {RAM_DIN, RAM_DIN}
MEM_ACK  in  1  one-cycle completion pulse
MEM_RDATA  in  16  read word, valid on the MEM_ACK cycle
BUSY  out  1  state != IDLE
ERR  out  1  sticky timeout flag

Behaviour:
- Reset (RESET_n=0 at a CLK edge): state=IDLE; MEM_REQ/MEM_WE/MEM_RFSH=0; MEM_ADDR/MEM_BE/MEM_WDATA=0; RAM_DOUT data register=0; cache invalid; refresh pending=0; ERR=0; prev_oe_n/prev_we_n/prev_rfsh_n=1. Reset in mid-transaction drops MEM_REQ at that edge; a late MEM_ACK is ignored.
- Edge detect: prev_* registers update every cycle. rd_start = prev_oe_n & !RAM_OE_n. wr_start = prev_we_n & !RAM_WE_n. rfsh_start = prev_rfsh_n & !RAM_RFSH_n.
- If rd_start and wr_start occur in the same cycle, the write wins and the read is discarded.
- A start detected while not IDLE is latched as one pending access (the latest one overwrites). It launches on the first IDLE cycle.
- States: IDLE, RD, WR, RFSH.
- IDLE priority: write > read > refresh pending.
  - Write: enter WR; drive MEM_REQ=1, MEM_WE=1, MEM_BE=ADDR[0]?2'b10:2'b01, MEM_WDATA={DIN,DIN}.
  - Read hit (USE_CACHE, cache valid, word address equal): no request; the data register loads the cached byte at this edge.
  - Read miss: enter RD; drive MEM_REQ=1, MEM_WE=0, MEM_BE=2'b11.
  - Refresh: enter RFSH; drive MEM_REQ=1, MEM_RFSH=1.
- Handshake:
  - MEM_REQ and all MEM_* fields are stable from launch until the MEM_ACK cycle.
  - On the MEM_ACK edge: MEM_REQ=0 and state returns to IDLE.
  - MEM_ACK while MEM_REQ=0 is ignored.
  - Back-to-back requests need at least one cycle with MEM_REQ=0.
- Read completion: on MEM_ACK the cache loads {word address, MEM_RDATA} and sets valid; the data register loads the byte selected by ADDR[0] (0→[7:0], 1→[15:8]).
- Write completion: if the written word is cached, the addressed cache byte is updated at the ACK edge.
- Read latency: hit → data visible the cycle after detection; miss → the cycle after MEM_ACK.
- RAM_DOUT = RAM_OE_n ? 0 : {8'h00, data register}. It is 0 whenever OE_n is high, so downstream OR-combining works. If OE_n rises before ACK, the transaction still completes and fills the cache, but nothing is presented.
- Refresh: rfsh_start sets the pending flag. A second edge while pending is merged (no counter). The flag clears on RFSH ACK.
- Timeout: an 8-bit (clog2) counter runs while MEM_REQ=1 and clears at launch. When it reaches TIMEOUT_CYCLES: MEM_REQ=0, IDLE, ERR=1, the data register is loaded with 8'hFF for a read, and the cache is unchanged. ERR clears only on reset.

Decomposition:
- Package ram_seq_pkg: state enum (IDLE, RD, WR, RFSH); mem_cmd_t struct (we, rfsh, addr, be, wdata); BE constants.
- Sub-module ram_read_cache: one-entry tag/data/valid register with lookup, fill, byte-update and invalidate ports. It is instantiated only when USE_CACHE=1.

Test Plan:
- Read miss: OE_n falls with ADDR=0x000101, back-end ACKs 3 cycles after REQ with RDATA=0xA55A → MEM_ADDR=0x000080, BE=11; RAM_DOUT=0x00A5 the cycle after ACK; BUSY high for 4 cycles.
- Read hit: immediate re-read of 0x000100 → no MEM_REQ; RAM_DOUT=0x005A one cycle after the OE_n edge.
- Write: WE_n falls at ADDR=0x000100 with DIN=0x3C → REQ with WE=1, BE=01, WDATA=0x3C3C; a subsequent read of 0x000100 hits and returns 0x003C.
- Simultaneous events: WE_n and OE_n fall together while RFSH_n also falls → only the write issues, then the refresh (MEM_RFSH=1); no read request appears.
- Timeout: a read with MEM_ACK never asserted → REQ drops after 255 cycles, ERR=1, RAM_DOUT=0x00FF while OE_n is low; a late ACK has no effect.
- Reset mid-read: RESET_n low while REQ=1 → REQ=0 at the next edge; cache invalid; a following read of the same address issues a new request.
